// File: rtl/answer_voter_pkg.sv
// Shared answer codes and voter state encodings used by answer_voter and its tally.
package answer_voter_pkg;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      R_B  = 3'd1,
      R_G  = 3'd2,
      B_G  = 3'd3,
      STOP = 3'd4
   } answer_t;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DECIDE  = 2'd1,
      REPORT  = 2'd2
   } state_t;

   localparam int NUM_CODES = 5;

   // Rank 0 wins ties, so tallies are stored in tie-break priority order.
   function automatic answer_t rank_code(input int rank);
      case (rank)
         0:       return STOP;
         1:       return R_B;
         2:       return R_G;
         3:       return B_G;
         default: return NONE;
      endcase
   endfunction

endpackage

// File: rtl/answer_voter_tally.sv
// Five per-code vote tallies with a combinational priority argmax (STOP > R_B > R_G > B_G > NONE).
// Illegal codes add no vote; STOP_WINS makes any nonzero STOP tally win outright.
module vote_tally
   import answer_voter_pkg::*;
#(
   parameter int CW        = 4,
   parameter bit STOP_WINS = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [2:0]    code,
   output logic [2:0]    win_code,
   output logic [CW-1:0] win_cnt
);

   logic [CW-1:0] tally_q [NUM_CODES];
   logic [CW-1:0] tally_d [NUM_CODES];

   always_comb begin
      for (int i = 0; i < NUM_CODES; i++) begin
         tally_d[i] = tally_q[i];
         if (clr) begin
            tally_d[i] = '0;
         end else if (inc && (code == rank_code(i))) begin
            tally_d[i] = tally_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CODES; i++) begin
         if (rst) tally_q[i] <= '0;
         else     tally_q[i] <= tally_d[i];
      end
   end

   always_comb begin
      win_code = STOP;
      win_cnt  = tally_q[0];
      for (int i = 1; i < NUM_CODES; i++) begin
         if (tally_q[i] > win_cnt) begin
            win_code = rank_code(i);
            win_cnt  = tally_q[i];
         end
      end
      if (STOP_WINS && (tally_q[0] != '0)) begin
         win_code = STOP;
         win_cnt  = tally_q[0];
      end
   end

endmodule

// File: rtl/answer_voter.sv
// Majority vote over WINDOW accepted samples; decision strobes 1 cycle after the last accept, ready drops for 2 cycles.
// VOTE_STOP_OVERRIDE_EN: an accepted STOP closes the window and is reported regardless of THRESH.
module answer_voter
   import answer_voter_pkg::*;
#(
   parameter int WINDOW = 8,
   parameter int THRESH = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] sampleAnswer,
   input  logic       sampleValid,
   output logic       sampleReady,
   output logic [2:0] finalAnswer,
   output logic       finalDone,
   output logic [7:0] winVotes
);

   localparam int CW = $clog2(WINDOW + 1);

`ifdef VOTE_STOP_OVERRIDE_EN
   localparam bit STOP_OVR = 1'b1;
`else
   localparam bit STOP_OVR = 1'b0;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    answer_q, answer_d;
   logic [7:0]    votes_q, votes_d;
   logic          done_q, done_d;

   logic          accept;
   logic          tally_clr;
   logic          stop_end;
   logic          stop_forced;
   logic [2:0]    win_code;
   logic [CW-1:0] win_cnt;

   vote_tally #(
      .CW        (CW),
      .STOP_WINS (STOP_OVR)
   ) u_tally (
      .clk      (clk),
      .rst      (rst),
      .clr      (tally_clr),
      .inc      (accept),
      .code     (sampleAnswer),
      .win_code (win_code),
      .win_cnt  (win_cnt)
   );

   assign accept = sampleValid && (state_q == COLLECT);

`ifdef VOTE_STOP_OVERRIDE_EN
   assign stop_end    = (sampleAnswer == STOP);
   // An all-illegal window also lands on STOP with zero votes; that must still obey THRESH.
   assign stop_forced = (win_code == STOP) && (win_cnt != '0);
`else
   assign stop_end    = 1'b0;
   assign stop_forced = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      answer_d  = answer_q;
      votes_d   = votes_q;
      done_d    = 1'b0;
      tally_clr = 1'b0;
      case (state_q)
         COLLECT: begin
            if (accept) begin
               cnt_d = cnt_q + CW'(1);
               if ((cnt_d == CW'(WINDOW)) || stop_end) state_d = DECIDE;
            end
         end
         DECIDE: begin
            if (stop_forced || (win_cnt >= CW'(THRESH))) begin
               answer_d = win_code;
               votes_d  = 8'(win_cnt);
            end else begin
               answer_d = NONE;
               votes_d  = 8'd0;
            end
            done_d    = 1'b1;
            tally_clr = 1'b1;
            cnt_d     = '0;
            state_d   = REPORT;
         end
         REPORT: begin
            state_d = COLLECT;
         end
         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= COLLECT;
         cnt_q    <= '0;
         answer_q <= NONE;
         votes_q  <= 8'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         answer_q <= answer_d;
         votes_q  <= votes_d;
         done_q   <= done_d;
      end
   end

   assign sampleReady = (state_q == COLLECT);
   assign finalAnswer = answer_q;
   assign finalDone   = done_q;
   assign winVotes    = votes_q;

endmodule

// File: tb/tb_answer_voter.sv
// Bench for answer_voter: two instances (THRESH 5 and 4) share one stimulus stream and are
// checked every cycle against a window-list reference model, plus literal expectations per test.
module tb_answer_voter;

   localparam int WIN = 8;
   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_RB   = 3'd1;
   localparam logic [2:0] C_RG   = 3'd2;
   localparam logic [2:0] C_BG   = 3'd3;
   localparam logic [2:0] C_STOP = 3'd4;
   localparam logic [2:0] C_BAD  = 3'd7;

`ifdef VOTE_STOP_OVERRIDE_EN
   localparam bit OVR = 1'b1;
`else
   localparam bit OVR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       sample_valid;
   logic [2:0] sample_answer;
   logic       rdy5, done5, rdy4, done4;
   logic [2:0] ans5, ans4;
   logic [7:0] v5, v4;

   answer_voter #(.WINDOW(WIN), .THRESH(5)) u_dut5 (
      .clk(clk), .rst(rst), .sampleAnswer(sample_answer), .sampleValid(sample_valid),
      .sampleReady(rdy5), .finalAnswer(ans5), .finalDone(done5), .winVotes(v5)
   );

   answer_voter #(.WINDOW(WIN), .THRESH(4)) u_dut4 (
      .clk(clk), .rst(rst), .sampleAnswer(sample_answer), .sampleValid(sample_valid),
      .sampleReady(rdy4), .finalAnswer(ans4), .finalDone(done4), .winVotes(v4)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int dut_dones = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: list of samples in the open window and a count of busy cycles after it closes.
   logic [2:0] win_q[$];
   int         busy = 0;
   bit         m_done = 1'b0;
   logic [2:0] m_ans5 = C_NONE, m_ans4 = C_NONE;
   logic [7:0] m_v5 = 8'd0, m_v4 = 8'd0;

   function automatic void decide(input int thresh, output logic [2:0] a, output logic [7:0] v);
      int cnt[8];
      int prio[5];
      int best;
      prio = '{4, 1, 2, 3, 0};
      for (int c = 0; c < 8; c++) cnt[c] = 0;
      foreach (win_q[i]) cnt[win_q[i]]++;
      if (OVR && cnt[C_STOP] > 0) begin
         a = C_STOP;
         v = 8'(cnt[C_STOP]);
         return;
      end
      best = prio[0];
      for (int k = 1; k < 5; k++) if (cnt[prio[k]] > cnt[best]) best = prio[k];
      if (cnt[best] < thresh) begin
         a = C_NONE;
         v = 8'd0;
      end else begin
         a = 3'(best);
         v = 8'(cnt[best]);
      end
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         win_q.delete();
         busy   = 0;
         m_done = 1'b0;
         m_ans5 = C_NONE; m_ans4 = C_NONE;
         m_v5   = 8'd0;   m_v4   = 8'd0;
      end else begin
         m_done = 1'b0;
         if (busy == 2) begin
            decide(5, m_ans5, m_v5);
            decide(4, m_ans4, m_v4);
            m_done = 1'b1;
            win_q.delete();
            busy = 1;
         end else if (busy == 1) begin
            busy = 0;
         end else if (sample_valid) begin
            win_q.push_back(sample_answer);
            if (win_q.size() == WIN || (OVR && sample_answer == C_STOP)) busy = 2;
         end
      end
   end

   always @(negedge clk) begin
      if (done5 === 1'b1) dut_dones++;
      chk("ready5", 32'(rdy5), 32'(busy == 0));
      chk("ready4", 32'(rdy4), 32'(busy == 0));
      chk("done5",  32'(done5), 32'(m_done));
      chk("done4",  32'(done4), 32'(m_done));
      chk("ans5",   32'(ans5), 32'(m_ans5));
      chk("ans4",   32'(ans4), 32'(m_ans4));
      chk("votes5", 32'(v5), 32'(m_v5));
      chk("votes4", 32'(v4), 32'(m_v4));
   end

   // Called right after a negedge; returns right after the negedge following the accepting edge.
   task automatic send(input logic [2:0] code);
      int tries = 0;
      sample_valid  = 1'b1;
      sample_answer = code;
      while (rdy5 !== 1'b1 && tries < 20) begin
         @(negedge clk);
         tries++;
      end
      if (tries >= 20) chk("send_timeout", 32'(rdy5), 32'd1);
      @(negedge clk);
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (done5 !== 1'b1 && cyc < 30);
      chk("wait_done", 32'(done5), 32'd1);
   endtask

   task automatic pulse_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int d0;
      logic [2:0] fav;
      rst           = 1'b1;
      sample_valid  = 1'b0;
      sample_answer = C_NONE;
      repeat (3) @(negedge clk);
      chk("rst_ans",   32'(ans5), 32'(C_NONE));
      chk("rst_done",  32'(done5), 32'd0);
      chk("rst_votes", 32'(v5), 32'd0);
      chk("rst_ready", 32'(rdy5), 32'd1);
      rst = 1'b0;

      // 8 x R_G back to back
      for (int i = 0; i < 8; i++) send(C_RG);
      wait_done(cyc);
      chk("t1_latency", 32'(cyc), 32'd1);
      chk("t1_ans",     32'(ans5), 32'(C_RG));
      chk("t1_votes",   32'(v5), 32'd8);
      chk("t1_model",   32'(m_v5), 32'd8);
      chk("t1_ready_lo", 32'(rdy5), 32'd0);

      // 4 x R_B + 4 x B_G: below THRESH 5, tie to R_B at THRESH 4
      for (int i = 0; i < 4; i++) send(C_RB);
      for (int i = 0; i < 4; i++) send(C_BG);
      wait_done(cyc);
      chk("t2_ans5",   32'(ans5), 32'(C_NONE));
      chk("t2_votes5", 32'(v5), 32'd0);
      chk("t2_ans4",   32'(ans4), 32'(C_RB));
      chk("t2_votes4", 32'(v4), 32'd4);
      chk("t2_model4", 32'(m_ans4), 32'(C_RB));

      // 3 illegal codes count toward the window only
      send(C_BAD); send(C_BG); send(C_BAD); send(C_BG);
      send(C_BAD); send(C_BG); send(C_BG);
      chk("t3_not_early", 32'(busy), 32'd0);
      send(C_BG);
      wait_done(cyc);
      chk("t3_latency", 32'(cyc), 32'd1);
      chk("t3_ans",     32'(ans5), 32'(C_BG));
      chk("t3_votes",   32'(v5), 32'd5);
      chk("t3_model",   32'(m_ans5), 32'(C_BG));

      // reset mid-window discards partial samples
      for (int i = 0; i < 5; i++) send(C_RB);
      d0 = dut_dones;
      pulse_reset();
      repeat (3) @(negedge clk);
      chk("t4_no_strobe", 32'(dut_dones), 32'(d0));
      for (int i = 0; i < 8; i++) send(C_RG);
      wait_done(cyc);
      chk("t4_ans",   32'(ans5), 32'(C_RG));
      chk("t4_votes", 32'(v5), 32'd8);

      // R_B, R_B, STOP
      repeat (2) @(negedge clk);
      send(C_RB); send(C_RB); send(C_STOP);
`ifdef VOTE_STOP_OVERRIDE_EN
      wait_done(cyc);
      chk("t5_latency", 32'(cyc), 32'd1);
      chk("t5_ans",     32'(ans5), 32'(C_STOP));
      chk("t5_votes",   32'(v5), 32'd1);
      chk("t5_ans4",    32'(ans4), 32'(C_STOP));
      chk("t5_model",   32'(m_v5), 32'd1);
`else
      d0 = dut_dones;
      repeat (4) @(negedge clk);
      chk("t5_no_end",   32'(dut_dones), 32'(d0));
      chk("t5_ready_hi", 32'(rdy5), 32'd1);
      for (int i = 0; i < 5; i++) send(C_RG);
      wait_done(cyc);
      chk("t5_ans",   32'(ans5), 32'(C_RG));
      chk("t5_votes", 32'(v5), 32'd5);
      chk("t5_model", 32'(m_ans5), 32'(C_RG));
`endif

      // randomized traffic with idle gaps and occasional resets
      fav = C_RB;
      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            pulse_reset();
         end else if (r < 20) begin
            sample_answer = 3'($urandom_range(0, 7));
            @(negedge clk);
         end else begin
            if ($urandom_range(0, 15) == 0) fav = 3'($urandom_range(0, 4));
            if ($urandom_range(0, 2) == 0) send(3'($urandom_range(0, 7)));
            else send(fav);
         end
      end

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
